// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks the register file read port and streams each register value out
//
// Purpose:
//   On a Start pulse, reads registers 0..NUM_REGS-1 through the register file's
//   combinational read port, one per FETCH cycle, and presents each captured value
//   as one beat on a valid/ready output stream. Never writes the register file.
//
// Ports:
//   Clk       - clock, all state on rising edge
//   Reset     - synchronous, active-high reset
//   Start     - dump request, only honoured while idle
//   RdAddr    - read address to the register file
//   RdData    - combinational read data for RdAddr
//   OutData   - stream beat data
//   OutValid  - stream beat valid
//   OutReady  - downstream ready
//   Busy      - high whenever not idle
//   Done      - one-cycle pulse after the final beat has been accepted
//
// Optional feature:
//   REGDUMP_CHECKSUM_EN - when defined, an XOR of all register beats is sent as one
//   extra beat before Done.

module regfile_dump_reader #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q,       acc_d;
`endif

    logic handshake;
    assign handshake = out_valid_q && OutReady;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d       = acc_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d   = S_FETCH;
                    cnt_d     = '0;
                    rd_addr_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d     = '0;
`endif
                end
            end

            // RdAddr has been stable for this whole cycle, so RdData is the
            // value of the register as it stood before this edge's write.
            S_FETCH: begin
                out_data_d  = RdData;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end

            S_SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d       = acc_q ^ out_data_q;
`endif
                    if (cnt_q == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        cnt_d     = cnt_q + ADDR_W'(1);
                        rd_addr_d = cnt_q + ADDR_W'(1);
                        state_d   = S_FETCH;
                    end
                end
            end

`ifdef REGDUMP_CHECKSUM_EN
            // First cycle here loads the accumulator (mirrors the FETCH slot),
            // then the beat is held until accepted.
            S_CSUM: begin
                if (!out_valid_q) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                end else if (OutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign RdAddr   = rd_addr_q;
    assign OutData  = out_data_q;
    assign OutValid = out_valid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
